// File: rtl/alu_ctrl.sv
// Issue/writeback controller for the 12-bit ALU: 3-cycle IDLE/EXEC/WB sequence, small regfile, flags.
// Optional ALU_CTRL_NOWB_EN adds instr_nowb to suppress the register write (flags still update).
module alu_ctrl #(
   parameter int unsigned NREGS  = 4,
   parameter int unsigned DATA_W = 12,
   localparam int unsigned IdxW  = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [IdxW-1:0]   instr_rd,
   input  logic [IdxW-1:0]   instr_ra,
   input  logic [IdxW-1:0]   instr_rb,
   input  logic              instr_imm_sel,
   input  logic [DATA_W-1:0] instr_imm,
   input  logic              instr_use_carry,
`ifdef ALU_CTRL_NOWB_EN
   input  logic              instr_nowb,
`endif
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_carry_in,
   output logic [2:0]        alu_func,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   input  logic              alu_equ,
   input  logic              alu_overflow,
   output logic [4:0]        flags,
   output logic              done,
   input  logic [IdxW-1:0]   dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StWb
   } state_e;

   state_e              state_q, state_d;
   logic                accept;
   logic                wb_en;

   logic [2:0]          op_q;
   logic [IdxW-1:0]     rd_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic                cin_q;

   logic [DATA_W-1:0]   res_q;
   logic                res_c_q;
   logic                res_e_q;
   logic                res_v_q;

   logic [4:0]          flags_q;
   logic                done_q;
   logic [DATA_W-1:0]   regs_q [NREGS];

`ifdef ALU_CTRL_NOWB_EN
   logic                nowb_q;
   assign wb_en = ~nowb_q;
`else
   assign wb_en = 1'b1;
`endif

   assign instr_ready = (state_q == StIdle);
   assign accept      = instr_valid & instr_ready;
   assign flags       = flags_q;
   assign done        = done_q;
   assign dbg_data    = regs_q[dbg_sel];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StExec;
         StExec:  state_d = StWb;
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ALU inputs are only meaningful during EXEC; keep them quiet otherwise.
   always_comb begin
      alu_a        = '0;
      alu_b        = '0;
      alu_carry_in = 1'b0;
      alu_func     = '0;
      if (state_q == StExec) begin
         alu_a        = a_q;
         alu_b        = b_q;
         alu_carry_in = cin_q;
         alu_func     = op_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         res_q   <= '0;
         res_c_q <= 1'b0;
         res_e_q <= 1'b0;
         res_v_q <= 1'b0;
         flags_q <= '0;
         done_q  <= 1'b0;
`ifdef ALU_CTRL_NOWB_EN
         nowb_q  <= 1'b0;
`endif
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == StWb);

         if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            a_q   <= regs_q[instr_ra];
            b_q   <= instr_imm_sel ? instr_imm : regs_q[instr_rb];
            // Carry flag is sampled here, not at EXEC.
            cin_q <= instr_use_carry & flags_q[4];
`ifdef ALU_CTRL_NOWB_EN
            nowb_q <= instr_nowb;
`endif
         end

         if (state_q == StExec) begin
            res_q   <= alu_result;
            res_c_q <= alu_carry;
            res_e_q <= alu_equ;
            res_v_q <= alu_overflow;
         end

         // r0 is never written, so it keeps its reset value of zero.
         if (state_q == StWb) begin
            if ((rd_q != '0) && wb_en) begin
               regs_q[rd_q] <= res_q;
            end
            flags_q <= {res_c_q, (res_q == '0), res_e_q, res_q[DATA_W-1], res_v_q};
         end
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized self-checking bench for alu_ctrl; includes a behavioural ALU and a register/flag model.
module tb_alu_ctrl;

   localparam logic [2:0] OpAdd  = 3'd0;
   localparam logic [2:0] OpSub  = 3'd1;
   localparam logic [2:0] OpRotL = 3'd2;
   localparam logic [2:0] OpRotR = 3'd3;
   localparam logic [2:0] OpXor  = 3'd4;
   localparam logic [2:0] OpAnd  = 3'd5;
   localparam logic [2:0] OpOr   = 3'd6;
   localparam logic [2:0] OpNot  = 3'd7;

   logic        clk, rst_n;
   logic        instr_valid, instr_ready;
   logic [2:0]  instr_op;
   logic [1:0]  instr_rd, instr_ra, instr_rb;
   logic        instr_imm_sel;
   logic [11:0] instr_imm;
   logic        instr_use_carry;
   logic        instr_nowb;
   logic [11:0] alu_a, alu_b, alu_result;
   logic        alu_carry_in, alu_carry, alu_equ, alu_overflow;
   logic [2:0]  alu_func;
   logic [4:0]  flags;
   logic        done;
   logic [1:0]  dbg_sel;
   logic [11:0] dbg_data;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [11:0] mregs [4];
   logic [4:0]  mflags;

   alu_ctrl #(.NREGS(4), .DATA_W(12)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_op        (instr_op),
      .instr_rd        (instr_rd),
      .instr_ra        (instr_ra),
      .instr_rb        (instr_rb),
      .instr_imm_sel   (instr_imm_sel),
      .instr_imm       (instr_imm),
      .instr_use_carry (instr_use_carry),
`ifdef ALU_CTRL_NOWB_EN
      .instr_nowb      (instr_nowb),
`endif
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_carry_in    (alu_carry_in),
      .alu_func        (alu_func),
      .alu_result      (alu_result),
      .alu_carry       (alu_carry),
      .alu_equ         (alu_equ),
      .alu_overflow    (alu_overflow),
      .flags           (flags),
      .done            (done),
      .dbg_sel         (dbg_sel),
      .dbg_data        (dbg_data)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Returns {overflow, equ, carry, result}.
   function automatic logic [14:0] alu_fn(input logic [2:0] f, input logic [11:0] a,
                                          input logic [11:0] b, input logic cin);
      logic [12:0] wide;
      logic [11:0] r;
      logic        c, v;
      int          sh;
      c = 1'b0;
      v = 1'b0;
      r = '0;
      sh = int'(b[3:0]) % 12;
      case (f)
         OpAdd: begin
            wide = {1'b0, a} + {1'b0, b} + {12'd0, cin};
            r = wide[11:0];
            c = wide[12];
            v = (a[11] == b[11]) && (r[11] != a[11]);
         end
         OpSub: begin
            wide = {1'b0, a} - {1'b0, b} - {12'd0, cin};
            r = wide[11:0];
            c = wide[12];
            v = (a[11] != b[11]) && (r[11] != a[11]);
         end
         OpRotL: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[10:0], r[11]};
         end
         OpRotR: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[0], r[11:1]};
         end
         OpXor: r = a ^ b;
         OpAnd: r = a & b;
         OpOr:  r = a | b;
         default: r = ~a;
      endcase
      return {v, (a == b), c, r};
   endfunction

   always_comb begin
      {alu_overflow, alu_equ, alu_carry, alu_result} = alu_fn(alu_func, alu_a, alu_b, alu_carry_in);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         check_eq($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(mregs[i]));
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      mflags = '0;
   endtask

   task automatic scramble_instr();
      instr_op        = 3'($urandom);
      instr_rd        = 2'($urandom);
      instr_ra        = 2'($urandom);
      instr_rb        = 2'($urandom);
      instr_imm_sel   = 1'($urandom);
      instr_imm       = 12'($urandom);
      instr_use_carry = 1'($urandom);
      instr_nowb      = 1'($urandom);
   endtask

   // Issues one instruction and follows it through EXEC, WB and the done cycle.
   task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic isel, input logic [11:0] imm,
                        input logic uc, input logic nowb, input logic hold);
      logic [11:0] a, b;
      logic        cin;
      logic [14:0] r;
      int          waitc;
      @(negedge clk);
      waitc = 0;
      while (!instr_ready && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      if (!instr_ready) begin
         check_eq("ready_wait", 32'(instr_ready), 32'd1);
         return;
      end
      instr_valid     = 1'b1;
      instr_op        = op;
      instr_rd        = rd;
      instr_ra        = ra;
      instr_rb        = rb;
      instr_imm_sel   = isel;
      instr_imm       = imm;
      instr_use_carry = uc;
      instr_nowb      = nowb;
      a   = mregs[ra];
      b   = isel ? imm : mregs[rb];
      cin = uc & mflags[4];
      r   = alu_fn(op, a, b, cin);

      @(posedge clk); #1;
      instr_valid = hold;
      scramble_instr();
      check_eq("exec_ready", 32'(instr_ready), 32'd0);
      check_eq("exec_done", 32'(done), 32'd0);
      check_eq("exec_alu_a", 32'(alu_a), 32'(a));
      check_eq("exec_alu_b", 32'(alu_b), 32'(b));
      check_eq("exec_func", 32'(alu_func), 32'(op));
      check_eq("exec_cin", 32'(alu_carry_in), 32'(cin));

      if (rd != 2'd0 && !nowb) mregs[rd] = r[11:0];
      mflags = {r[12], (r[11:0] == 12'd0), r[13], r[11], r[14]};

      @(posedge clk); #1;
      check_eq("wb_ready", 32'(instr_ready), 32'd0);
      check_eq("wb_done", 32'(done), 32'd0);
      check_eq("wb_alu_a", 32'(alu_a), 32'd0);
      check_eq("wb_func", 32'(alu_func), 32'd0);

      @(posedge clk); #1;
      check_eq("done_pulse", 32'(done), 32'd1);
      check_eq("done_ready", 32'(instr_ready), 32'd1);
      check_eq("done_flags", 32'(flags), 32'(mflags));
      check_all_regs("wb");
   endtask

   task automatic check_reg_const(input string tag, input logic [1:0] idx, input logic [11:0] exp);
      dbg_sel = idx;
      #1;
      check_eq(tag, 32'(dbg_data), 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic nowb_r;
      logic hold_prev;
      rst_n = 1'b0;
      instr_valid = 1'b0;
      dbg_sel = '0;
      scramble_instr();
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(instr_ready), 32'd1);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_flags", 32'(flags), 32'd0);
      check_eq("rst_alu_a", 32'(alu_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_ready", 32'(instr_ready), 32'd1);
      check_all_regs("rst");

      // Directed scenarios with hand-computed results.
      issue(OpOr, 2'd1, 2'd0, 2'd0, 1'b1, 12'h7FF, 1'b0, 1'b0, 1'b0);
      check_reg_const("t1_r1", 2'd1, 12'h7FF);
      check_eq("t1_flags", 32'(flags), 32'h00);

      issue(OpAdd, 2'd1, 2'd1, 2'd0, 1'b1, 12'h001, 1'b0, 1'b0, 1'b0);
      check_reg_const("t2_r1", 2'd1, 12'h800);
      check_eq("t2_flags", 32'(flags), 32'h03);

      issue(OpOr, 2'd2, 2'd0, 2'd0, 1'b1, 12'h001, 1'b0, 1'b0, 1'b0);
      issue(OpAdd, 2'd2, 2'd2, 2'd0, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
      check_reg_const("t3_r2", 2'd2, 12'h000);
      check_eq("t3_flags", 32'(flags), 32'h18);
      issue(OpAdd, 2'd3, 2'd0, 2'd0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
      check_reg_const("t3_r3", 2'd3, 12'h001);
      check_eq("t3b_flags", 32'(flags), 32'h04);

`ifdef ALU_CTRL_NOWB_EN
      issue(OpSub, 2'd1, 2'd1, 2'd0, 1'b1, 12'h800, 1'b0, 1'b1, 1'b0);
      check_reg_const("nowb_r1", 2'd1, 12'h800);
      check_eq("nowb_flags", 32'(flags), 32'h0C);
`endif

      // Valid held high across three back-to-back instructions.
      issue(OpXor, 2'd1, 2'd1, 2'd3, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      issue(OpRotL, 2'd2, 2'd1, 2'd0, 1'b1, 12'h005, 1'b0, 1'b0, 1'b1);
      issue(OpSub, 2'd3, 2'd2, 2'd1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);

      // Random instruction stream, occasionally back-to-back.
      hold_prev = 1'b0;
      for (int i = 0; i < 80; i++) begin
         logic hold;
         if (!hold_prev) repeat ($urandom_range(0, 2)) @(posedge clk);
         hold = (i < 79) ? 1'($urandom) : 1'b0;
`ifdef ALU_CTRL_NOWB_EN
         nowb_r = ($urandom_range(0, 3) == 0);
`else
         nowb_r = 1'b0;
`endif
         issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
               12'($urandom), 1'($urandom), nowb_r, hold);
         hold_prev = hold;
      end

      // Ensure a visible register value before the abort test.
      issue(OpOr, 2'd1, 2'd0, 2'd0, 1'b1, 12'h3C3, 1'b0, 1'b0, 1'b0);

      // Reset asserted during EXEC aborts without writeback.
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op = OpXor;
      instr_rd = 2'd1;
      instr_ra = 2'd1;
      instr_imm_sel = 1'b1;
      instr_imm = 12'h5A5;
      instr_use_carry = 1'b0;
      instr_nowb = 1'b0;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      check_eq("abort_in_exec", 32'(instr_ready), 32'd0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_flags", 32'(flags), 32'd0);
      check_eq("abort_ready", 32'(instr_ready), 32'd1);
      check_all_regs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("abort_no_done", 32'(done), 32'd0);
      end
      issue(OpAnd, 2'd2, 2'd0, 2'd0, 1'b1, 12'hABC, 1'b0, 1'b0, 1'b0);
      issue(OpNot, 2'd3, 2'd0, 2'd0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
      check_reg_const("post_abort_r3", 2'd3, 12'hFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
